// File: rtl/key_schedule_seq_pkg.sv
// Shared DES key-schedule constants: FSM encodings, rotation schedule and
// the PC1/PC2 bit-selection tables with their mapping functions.
package key_schedule_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Left-rotation amount for DES rounds 1..16, indexed by round-1.
  localparam logic [1:0] SHIFT_T [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Table entries use DES numbering (bit 1 = MSB); vectors are [N-1:0].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return r;
  endfunction

endpackage

// File: rtl/key_schedule_seq_if.sv
// Key-load and subkey-stream handshake bundle for key_schedule_seq.
interface key_schedule_seq_if #(
  parameter int NUM_KEYS = 1
);
  logic [64*NUM_KEYS-1:0] key;
  logic                   decrypt;
  logic                   key_valid;
  logic                   key_ready;
  logic [47:0]            sk;
  logic                   sk_valid;
  logic                   sk_ready;
  logic [4:0]             sk_round;
  logic [1:0]             sk_stage;
  logic                   sk_dec;
  logic                   sk_last;
  logic                   busy;

  modport master (
    output key, decrypt, key_valid, sk_ready,
    input  key_ready, sk, sk_valid, sk_round, sk_stage, sk_dec, sk_last, busy
  );

  modport slave (
    input  key, decrypt, key_valid, sk_ready,
    output key_ready, sk, sk_valid, sk_round, sk_stage, sk_dec, sk_last, busy
  );
endinterface

// File: rtl/key_schedule_seq_rot28.sv
// 28-bit rotator: dir=0 rotates left, dir=1 rotates right; amt is 1 or 2.
module key_schedule_seq_rot28 (
  input  logic [27:0] din,
  input  logic        dir,
  input  logic [1:0]  amt,
  output logic [27:0] dout
);
  always_comb begin
    dout = din;
    if (!dir) dout = (amt == 2'd2) ? {din[25:0], din[27:26]} : {din[26:0], din[27]};
    else      dout = (amt == 2'd2) ? {din[1:0], din[27:2]}   : {din[0], din[27:1]};
  end
endmodule

// File: rtl/key_schedule_seq.sv
// Iterative DES/3DES subkey generator: one PC1 load per stage, then one
// 48-bit subkey per accepted transfer in encrypt or decrypt order.
module key_schedule_seq
  import key_schedule_seq_pkg::*;
#(
  parameter int NUM_KEYS = 1
) (
  input logic               clk,
  input logic               rst,
  key_schedule_seq_if.slave bus
);

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
    $error("key_schedule_seq: NUM_KEYS must be 1 or 3");
  end

  logic [1:0]             state_q, state_d;
  logic [1:0]             stage_q, stage_d;
  logic [4:0]             j_q, j_d;
  logic                   dec_q, dec_d;
  logic [64*NUM_KEYS-1:0] keys_q, keys_d;
  logic [55:0]            cd_q, cd_d;

  logic [63:0] key_arr [4];
  logic [1:0]  key_idx;
  logic        stage_dec;
  logic        last_stage;
  logic        run;
  logic [1:0]  shamt;
  logic [55:0] cd_rot;
  logic [55:0] pc2_in;
  logic [55:0] pc1_out;
  logic [47:0] sk_pc2;

  always_comb begin
    for (int k = 0; k < 4; k++) key_arr[k] = '0;
    for (int k = 0; k < NUM_KEYS; k++) key_arr[k] = keys_q[64*(NUM_KEYS-1-k) +: 64];
  end

  // Middle 3DES stage runs opposite to the outer ones; decrypt reverses key order.
  assign stage_dec  = dec_q ^ (stage_q == 2'd1);
  assign key_idx    = (NUM_KEYS == 1) ? 2'd0 : (dec_q ? (2'd2 - stage_q) : stage_q);
  assign last_stage = (stage_q == 2'(NUM_KEYS - 1));
  assign run        = (state_q == ST_RUN);
  assign shamt      = stage_dec ? SHIFT_T[4'(5'd16 - j_q)] : SHIFT_T[4'(j_q - 5'd1)];

  key_schedule_seq_rot28 u_rot_c (
    .din  (cd_q[55:28]),
    .dir  (stage_dec),
    .amt  (shamt),
    .dout (cd_rot[55:28])
  );

  key_schedule_seq_rot28 u_rot_d (
    .din  (cd_q[27:0]),
    .dir  (stage_dec),
    .amt  (shamt),
    .dout (cd_rot[27:0])
  );

  // Encrypt emits the post-rotation key; decrypt emits the current CD and
  // then rotates right, walking C16..C1 back to C0.
  assign pc2_in  = stage_dec ? cd_q : cd_rot;
  assign sk_pc2  = pc2(pc2_in);
  assign pc1_out = pc1(key_arr[key_idx]);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    dec_d   = dec_q;
    keys_d  = keys_q;
    cd_d    = cd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          keys_d  = bus.key;
          dec_d   = bus.decrypt;
          stage_d = 2'd0;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        cd_d    = pc1_out;
        j_d     = 5'd1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.sk_ready) begin
          cd_d = cd_rot;
          if (j_q == 5'd16) begin
            if (last_stage) begin
              state_d = ST_IDLE;
            end else begin
              stage_d = stage_q + 2'd1;
              state_d = ST_PREP;
            end
          end else begin
            j_d = j_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= 2'd0;
      j_q     <= 5'd0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      dec_q   <= dec_d;
    end
  end

  always_ff @(posedge clk) begin
    keys_q <= keys_d;
    cd_q   <= cd_d;
  end

  assign bus.key_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sk_valid  = run;
  assign bus.sk        = run ? sk_pc2 : 48'h0;
  assign bus.sk_round  = run ? (stage_dec ? (5'd17 - j_q) : j_q) : 5'd0;
  assign bus.sk_stage  = run ? stage_q : 2'd0;
  assign bus.sk_dec    = run & stage_dec;
  assign bus.sk_last   = run && (j_q == 5'd16) && last_stage;

endmodule

// File: doc/key_schedule_seq.md
# key_schedule_seq

Iterative, backpressured DES/3DES subkey generator. It loads one 64-bit key (NUM_KEYS=1) or three 64-bit keys (NUM_KEYS=3) and streams 48-bit round subkeys one per cycle, in encrypt or decrypt order. It replaces the 16-copy parallel combinational key schedule in datapaths where area matters and rounds are iterated, and it feeds the round engine directly.

## Interface
- NUM_KEYS, 1: number of 64-bit keys. Legal values are 1 (single DES) or 3 (3DES EDE). Any other value is an elaboration error.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key  in  64*NUM_KEYS  key bundle, bit 1 = MSB. Key1 occupies the most significant 64 bits; parity bits are ignored.
- decrypt  in  1  0 = encrypt order, 1 = decrypt order. Sampled with key.
- key_valid  in  1  key bundle offered.
- key_ready  out  1  high only in IDLE; a load occurs when key_valid && key_ready.
- sk  out  48  current subkey [48:1], bit 1 = MSB.
- sk_valid  out  1  sk is valid.
- sk_ready  in  1  consumer accepts sk; a transfer occurs when sk_valid && sk_ready.
- sk_round  out  5  DES subkey index of sk, 1..16.
- sk_stage  out  2  3DES stage 0..NUM_KEYS-1 in output order. Always 0 when NUM_KEYS=1.
- sk_dec  out  1  1 when the current stage uses decrypt ordering.
- sk_last  out  1  high on the final subkey of the whole bundle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE: key_valid && key_ready → PREP. All keys and decrypt are registered; stage counter = 0.
  - PREP: one cycle. CD ← PC1(key of current stage), with the 56-bit result split as C = bits 1..28 and D = bits 29..56. j ← 1. Next state is RUN.
  - RUN: one subkey per transfer. The last transfer with j=16 goes to PREP if stages remain; otherwise it goes to IDLE.
- Shift amount s(i) = 1 for i ∈ {1, 2, 9, 16}, else 2. C and D rotate independently, 28 bits each.
- Encrypt-ordered stage:
  - sk = PC2(rotl(CD, s(j))).
  - sk_round = j.
  - On transfer: CD ← rotl(CD, s(j)).
- Decrypt-ordered stage:
  - sk = PC2(CD).
  - sk_round = 17−j.
  - On transfer: CD ← rotr(CD, s(17−j)).
  - This works because C16/D16 equals C0/D0 after a total rotation of 28 bits.
- Stage mapping:
  - NUM_KEYS=1: stage 0 uses key1, ordered by decrypt.
  - NUM_KEYS=3, decrypt=0: stages use key1 enc, key2 dec, key3 enc.
  - NUM_KEYS=3, decrypt=1: stages use key3 dec, key2 enc, key1 dec.
- sk_last = (j==16) && (stage==NUM_KEYS−1) && RUN.
- Widths: j is 5 bits, range 1..16. The stage counter is 2 bits. No arithmetic wraps outside these ranges.

## Timing
- Reset values:
  - key_ready=1 (IDLE).
  - busy=0, sk_valid=0, sk_last=0, sk_dec=0.
  - sk_round=0, sk_stage=0.
  - sk = 48'h0 (output forced to zero while not valid).
- Latency:
  - A load accepted at edge T gives PREP in cycle T+1.
  - The first sk_valid is in cycle T+2.
  - With sk_ready held high, one subkey is delivered per cycle.
  - Each stage boundary inserts one PREP bubble (sk_valid=0).
  - A full bundle takes 17*NUM_KEYS cycles plus 1 cycle for the load.
- sk_valid is high exactly in RUN.
- While sk_valid && !sk_ready, all of sk, sk_round, sk_stage, sk_dec and sk_last hold stable.
- key_valid while busy is ignored. key, decrypt and key_valid need not be held after the load.
- rst asserted in any state: the block is in IDLE on the next cycle, with all outputs at reset values. Partial output is discarded.
- sk_ready asserted outside RUN has no effect.

## Structure
- des_pkg holds:
  - The shift schedule constant (16×2-bit).
  - The state enumeration (IDLE, PREP, RUN).
  - The PC1 and PC2 mapping tables or functions. The existing PC1 and PC2 modules are instantiated once each.
- One sub-module, rot28: bidirectional 28-bit rotator by 1 or 2 (inputs dir and amt). Instantiated for C and for D.

## Test plan
- Key 64'h133457799BBCDFF1, decrypt=0, sk_ready=1:
  - First sk = 48'h1B02EFFC7072 and second sk = 48'h79AED9DBC9E5 (sk_round 1, 2).
  - 16th sk = 48'hCB3D8B0E17F5 with sk_last=1.
  - busy drops on the next cycle.
- Same key with decrypt=1:
  - First sk = 48'hCB3D8B0E17F5 (sk_round=16).
  - Last sk = 48'h1B02EFFC7072 (sk_round=1).
  - The full sequence is the exact reverse of the encrypt run.
- Backpressure: sk_ready toggled randomly.
  - Outputs stay stable while stalled.
  - The 16 subkeys match the golden model in order, with no drops or duplicates.
- NUM_KEYS=3, keys K1 | K2 | K3 distinct, decrypt=0:
  - 48 subkeys in three stages; sk_stage goes 0, 1, 2.
  - sk_dec goes 0, 1, 0.
  - Each stage matches the per-key golden sequence.
  - Exactly one bubble between stages.
  - Repeat with decrypt=1: stages are K3 dec, K2 enc, K1 dec.
- rst pulsed in cycle 6 of RUN:
  - Next cycle: IDLE, sk_valid=0, key_ready=1.
  - A new load then produces the correct sequence from round 1.
- key_valid asserted during RUN with a different key: ignored, and the current sequence completes unchanged.
